// File: rtl/lint_to_apb_pkg.sv
// Shared types and constants for the lint-to-APB bridge.
package lint_to_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter with an expiry flag; expiry is
// permanently low when TIMEOUT_CYCLES is 0.
module apb_timeout_cnt
  import lint_to_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (inc_i && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      assign expired_o = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/lint_to_apb.sv
// Single-outstanding bridge from the lint req/gnt/r_valid interface to APB3,
// with a registered response and an optional pready timeout.
module lint_to_apb
  import lint_to_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_opc_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  state_e state;
  logic   expired;

  assign gnt_o = (state == IDLE) && req_i;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state == SETUP),
    .inc_i    ((state == ACCESS) && !pready_i),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      r_valid_o <= 1'b0;
      r_rdata_o <= '0;
      r_opc_o   <= RESP_OK;
    end else begin
      r_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            paddr_o  <= add_i;
            pwrite_o <= ~wen_i;
            // Reads leave the last write data on the bus untouched.
            if (!wen_i) pwdata_o <= wdata_i;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout expiring in the same cycle.
          if (pready_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            r_valid_o <= 1'b1;
            r_opc_o   <= pslverr_i;
            r_rdata_o <= pwrite_o ? '0 : prdata_i;
            state     <= IDLE;
          end else if (expired) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            r_valid_o <= 1'b1;
            r_opc_o   <= RESP_ERR;
            r_rdata_o <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lint_to_apb.sv
// Directed and randomized bench for lint_to_apb with a 4-cycle timeout.
module tb_lint_to_apb;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic        gnt_o;
  logic        r_valid_o;
  logic [31:0] r_rdata_o;
  logic        r_opc_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  lint_to_apb #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .add_i    (add),
    .wen_i    (wen),
    .wdata_i  (wdata),
    .gnt_o    (gnt_o),
    .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o),
    .r_opc_o  (r_opc_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .pwrite_o (pwrite_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .prdata_i (prdata),
    .pready_i (pready),
    .pslverr_i(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int rv_cnt   = 0;
  int exp_rv   = 0;

  logic [31:0] exp_pwdata = 32'h0;
  logic [32:0] last_resp  = 33'h0;

  logic [31:0] t_addr[8];
  logic        t_rd[8];
  logic [31:0] t_wd[8];
  int          t_wait[8];
  logic [31:0] t_prd[8];
  logic        t_err[8];

  always @(negedge clk) if (r_valid_o === 1'b1) rv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  // Reference response: timeout if the slave stalls TO or more cycles,
  // otherwise slave error flag plus read data (zero for writes).
  function automatic logic [32:0] model_resp(input logic rd, input int waits,
                                             input logic [31:0] prd, input logic err);
    if (waits >= TO) return {1'b1, 32'h0};
    return {err, rd ? prd : 32'h0};
  endfunction

  task automatic set_txn(input int k, input logic [31:0] a, input logic rd, input logic [31:0] wd,
                         input int waits, input logic [31:0] prd, input logic err);
    t_addr[k] = a; t_rd[k] = rd; t_wd[k] = wd; t_wait[k] = waits; t_prd[k] = prd; t_err[k] = err;
  endtask

  task automatic drive_req(input int k);
    req = 1'b1; add = t_addr[k]; wen = t_rd[k]; wdata = t_wd[k];
  endtask

  task automatic run_chain(input int n);
    logic [32:0] exp;
    int n_acc;
    @(posedge clk); #1;
    drive_req(0);
    @(negedge clk);
    chk1("gnt_idle", gnt_o, 1'b1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k < n - 1) drive_req(k + 1);
      else begin
        req = 1'b0; add = $urandom; wen = 1'($urandom); wdata = $urandom;
      end
      if (!t_rd[k]) exp_pwdata = t_wd[k];
      @(negedge clk);
      chk1("setup_psel", psel_o, 1'b1);
      chk1("setup_penable", penable_o, 1'b0);
      chk1("setup_gnt", gnt_o, 1'b0);
      chk1("setup_pwrite", pwrite_o, !t_rd[k]);
      chk("setup_paddr", paddr_o, t_addr[k]);
      chk("setup_pwdata", pwdata_o, exp_pwdata);
      chk1("setup_rvalid", r_valid_o, 1'b0);
      n_acc = (t_wait[k] < TO) ? t_wait[k] + 1 : TO;
      for (int i = 0; i < n_acc; i++) begin
        @(posedge clk); #1;
        pready  = (i == t_wait[k]);
        prdata  = pready ? t_prd[k] : $urandom;
        pslverr = pready ? t_err[k] : 1'($urandom);
        @(negedge clk);
        chk1("acc_psel", psel_o, 1'b1);
        chk1("acc_penable", penable_o, 1'b1);
        chk1("acc_pwrite", pwrite_o, !t_rd[k]);
        chk("acc_paddr", paddr_o, t_addr[k]);
        chk("acc_pwdata", pwdata_o, exp_pwdata);
        chk1("acc_gnt", gnt_o, 1'b0);
        chk1("acc_rvalid", r_valid_o, 1'b0);
      end
      @(posedge clk); #1;
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      exp = model_resp(t_rd[k], t_wait[k], t_prd[k], t_err[k]);
      last_resp = exp;
      exp_rv++;
      @(negedge clk);
      chk1("resp_rvalid", r_valid_o, 1'b1);
      chk1("resp_opc", r_opc_o, exp[32]);
      chk("resp_rdata", r_rdata_o, exp[31:0]);
      chk1("resp_psel", psel_o, 1'b0);
      chk1("resp_penable", penable_o, 1'b0);
      chk1("resp_gnt", gnt_o, k < n - 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk1("post_rvalid", r_valid_o, 1'b0);
    chk1("post_opc_hold", r_opc_o, last_resp[32]);
    chk("post_rdata_hold", r_rdata_o, last_resp[31:0]);
  endtask

  initial begin
    int n;
    int rv_before;
    rst = 1'b1; req = 1'b0; add = '0; wen = 1'b0; wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #12;
    chk1("rst_psel", psel_o, 1'b0);
    chk1("rst_penable", penable_o, 1'b0);
    chk1("rst_rvalid", r_valid_o, 1'b0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_pwdata", pwdata_o, 32'h0);
    chk("rst_rdata", r_rdata_o, 32'h0);
    chk1("rst_opc", r_opc_o, 1'b0);
    chk1("rst_gnt", gnt_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Read with immediate pready.
    set_txn(0, 32'h1A10_0004, 1'b1, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
    run_chain(1);
    // Write with 3 wait states: pready on the last cycle before timeout.
    set_txn(0, 32'h1A10_2000, 1'b0, 32'h1234_5678, 3, 32'hDEAD_BEEF, 1'b0);
    run_chain(1);
    // Back-to-back reads with req held high.
    set_txn(0, 32'h0000_1000, 1'b1, 32'hFFFF_0000, 0, 32'h1111_1111, 1'b0);
    set_txn(1, 32'h0000_2000, 1'b1, 32'hFFFF_0001, 0, 32'h2222_2222, 1'b0);
    set_txn(2, 32'h0000_3000, 1'b1, 32'hFFFF_0002, 0, 32'h3333_3333, 1'b0);
    run_chain(3);
    // Slave error on a read.
    set_txn(0, 32'h0000_4000, 1'b1, 32'h0, 0, 32'h5A5A_A5A5, 1'b1);
    run_chain(1);
    // Timeouts on a read and a write.
    set_txn(0, 32'h0000_5000, 1'b1, 32'h0, 100, 32'h7777_7777, 1'b0);
    run_chain(1);
    set_txn(0, 32'h0000_6000, 1'b0, 32'h0BAD_CAFE, 100, 32'h0, 1'b0);
    run_chain(1);
    // Write then read: read must leave pwdata at the write value.
    set_txn(0, 32'h0000_7000, 1'b0, 32'h4242_4242, 1, 32'h0, 1'b0);
    set_txn(1, 32'h0000_7004, 1'b1, 32'h9999_9999, 2, 32'h0F0F_0F0F, 1'b0);
    run_chain(2);

    // Randomized chains.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        set_txn(k, $urandom, 1'($urandom), $urandom, $urandom_range(0, 6),
                $urandom, ($urandom_range(0, 3) == 0));
      run_chain(n);
    end

    // Reset asserted mid-ACCESS.
    @(posedge clk); #1;
    req = 1'b1; add = 32'hABCD_0000; wen = 1'b0; wdata = 32'hAAAA_5555;
    @(negedge clk);
    chk1("rstmid_gnt", gnt_o, 1'b1);
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    pready = 1'b0;
    @(posedge clk); #1;
    rv_before = rv_cnt;
    #2 rst = 1'b1;
    #1;
    chk1("rstmid_psel", psel_o, 1'b0);
    chk1("rstmid_penable", penable_o, 1'b0);
    chk1("rstmid_pwrite", pwrite_o, 1'b0);
    chk("rstmid_paddr", paddr_o, 32'h0);
    chk("rstmid_pwdata", pwdata_o, 32'h0);
    chk1("rstmid_rvalid", r_valid_o, 1'b0);
    chk("rstmid_rdata", r_rdata_o, 32'h0);
    chk1("rstmid_opc", r_opc_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("rstrel_rvalid", r_valid_o, 1'b0);
      chk1("rstrel_psel", psel_o, 1'b0);
    end
    @(posedge clk); #1;
    pready = 1'b0;
    chk("rstrel_no_resp", rv_cnt, rv_before);
    last_resp = 33'h0;
    exp_pwdata = 32'h0;
    set_txn(0, 32'h0000_8000, 1'b1, 32'h0, 1, 32'h1357_9BDF, 1'b0);
    run_chain(1);

    chk("rvalid_pulse_count", rv_cnt, exp_rv);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lint_to_apb.md
Name: lint_to_apb

Overview:
Single-outstanding bridge that converts the core-side req/gnt/r_valid (lint) interface into APB3 setup/access transfers. It drives the slave port of the APB node (penable/pwrite/paddr/pwdata) and returns prdata/pready/pslverr to the requester as a registered response. It also provides psel_o for point-to-point use. An optional timeout aborts transfers stuck waiting for pready.

Parameters:
ADDR_WIDTH, 32, width of add_i/paddr_o
DATA_WIDTH, 32, width of wdata/rdata/pwdata/prdata
TIMEOUT_CYCLES, 0, max ACCESS cycles without pready before abort; 0 = timeout disabled

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
req_i  in  1  request valid
add_i  in  ADDR_WIDTH  request address
wen_i  in  1  1 = read, 0 = write
wdata_i  in  DATA_WIDTH  write data
gnt_o  out  1  request accepted this cycle
r_valid_o  out  1  response valid, one-cycle pulse
r_rdata_o  out  DATA_WIDTH  read data (0 for writes)
r_opc_o  out  1  1 = error (pslverr or timeout)
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
paddr_o  out  ADDR_WIDTH  APB address
pwdata_o  out  DATA_WIDTH  APB write data
prdata_i  in  DATA_WIDTH  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- Reset (rst_i=1, async): state IDLE. psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, r_valid_o, r_rdata_o, r_opc_o and the timeout counter are all 0. Any in-flight transfer is dropped and no response is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: gnt_o = req_i (combinational); gnt_o is 0 in every other state.
  - On req_i: register add_i, ~wen_i, wdata_i into paddr_o/pwrite_o/pwdata_o; next state SETUP.
  - pwdata_o is loaded only for writes; reads keep the previous value.
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0; next state ACCESS; counter cleared.
- ACCESS: psel_o=1, penable_o=1.
  - On pready_i=1: next state IDLE. Next cycle r_valid_o=1, r_opc_o=pslverr_i, r_rdata_o=prdata_i for reads, 0 for writes.
  - Otherwise the counter increments.
- Timeout (TIMEOUT_CYCLES>0 only): in ACCESS with pready_i=0 and counter==TIMEOUT_CYCLES-1, abort to IDLE. Next cycle r_valid_o=1, r_opc_o=1, r_rdata_o=0.
  - If pready_i=1 arrives in the same cycle as the timeout condition, pready wins and the transfer is a normal completion.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. The counter saturates, never wraps.
- paddr_o, pwrite_o and pwdata_o are registered and stable for the whole SETUP+ACCESS. They hold their last value in IDLE.
- r_valid_o is a 1-cycle pulse. r_rdata_o and r_opc_o hold their values until the next response.
- Back-to-back: r_valid_o and a new gnt_o may coincide (response cycle is IDLE).
  - Minimum 3 cycles per transfer: gnt at c0, SETUP c1, ACCESS+pready c2, r_valid c3 together with the next gnt.
- The requester must hold add_i/wen_i/wdata_i only while req_i=1 && gnt_o=0. The bridge samples them only on grant.
- req_i outside IDLE is ignored (no grant) until the bridge returns to IDLE.

Decomposition:
- Shared package lint_to_apb_pkg:
  - state_e enum {IDLE, SETUP, ACCESS}
  - localparam RESP_OK=1'b0, RESP_ERR=1'b1
- Sub-module apb_timeout_cnt: counter plus expiry flag, parameterised by TIMEOUT_CYCLES. Ties the expiry flag to 0 when TIMEOUT_CYCLES=0.

Test Plan:
- Read, pready=1 in first ACCESS: add=0x1A10_0004, wen=1, prdata=0xCAFE_F00D.
  -> gnt c0, psel c1-c2, penable c2, r_valid c3 with rdata=0xCAFE_F00D, opc=0.
- Write with 3 wait states: add=0x1A10_2000, wdata=0x1234_5678.
  -> pwrite=1, paddr/pwdata stable for 5 cycles (SETUP + 4 ACCESS), r_valid once, rdata=0, opc=0.
- Back-to-back reads with req_i held high.
  -> second gnt coincides with first r_valid, every 3 cycles, no dropped or duplicated response.
- pslverr=1 with pready=1 on a read.
  -> r_opc=1, rdata=prdata value, FSM back in IDLE.
- TIMEOUT_CYCLES=4, pready held 0.
  -> abort after 4 ACCESS cycles, r_valid with opc=1, rdata=0.
  -> Repeat with pready=1 on the 4th ACCESS cycle: normal completion, opc=0.
- rst_i asserted mid-ACCESS.
  -> all outputs 0 asynchronously, no r_valid after release, next request granted from IDLE normally.
